// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: self-sequencing radix-2 SDF NTT stage with CT/GS butterflies and a D-entry feedback FIFO.
// Build option: define SDF_BYPASS_EN to add a bypass input that turns the stage into a pure D-sample delay.
module sdf_stage_ctrl #(
  parameter int          DATA_W     = 64,
  parameter int unsigned MODULUS    = 7681,
  parameter int          DEPTH_LOG2 = 2,
  parameter int          TW_ADDR_W  = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 mode,
`ifdef SDF_BYPASS_EN
  input  logic                 bypass,
`endif
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    stage_in,
  input  logic [DATA_W-1:0]    tw_factor,
  output logic [TW_ADDR_W-1:0] tw_addr,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    stage_out
);
  localparam int D = 1 << DEPTH_LOG2;
  localparam logic [DATA_W:0]     Q1 = (DATA_W+1)'(MODULUS);
  localparam logic [2*DATA_W-1:0] Q2 = (2*DATA_W)'(MODULUS);
  localparam logic [DEPTH_LOG2:0] CNT_D = (DEPTH_LOG2+1)'(D);

  function automatic logic [DATA_W-1:0] add_q(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    logic [DATA_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= Q1) s = s - Q1;
    return s[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] sub_q(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    return (x >= y) ? x - y : DATA_W'({1'b0, x} + Q1 - {1'b0, y});
  endfunction

  function automatic logic [DATA_W-1:0] mul_q(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    return DATA_W'(({{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y}) % Q2);
  endfunction

  logic [DEPTH_LOG2:0]      cnt, cnt_nxt;
  logic                     primed, accept, phase, byp;
  logic [D-1:0][DATA_W-1:0] fifo;
  logic [DATA_W-1:0]        head, t_ct, sum_r, diff_r, buf_in, cand;
  logic [TW_ADDR_W-1:0]     tw_nxt;

`ifdef SDF_BYPASS_EN
  assign byp = bypass;
`else
  assign byp = 1'b0;
`endif

  assign accept  = in_valid & ~clear;
  assign cnt_nxt = cnt + 1'b1;
  assign phase   = cnt[DEPTH_LOG2];
  assign head    = fifo[D-1];
  assign t_ct    = mul_q(stage_in, tw_factor);

  // Address the ROM with the index of the next accepted sample so tw_factor is ready when it arrives.
  if (DEPTH_LOG2 > 0) begin : g_tw
    assign tw_nxt = byp ? '0 : TW_ADDR_W'(cnt_nxt[DEPTH_LOG2-1:0]);
  end else begin : g_tw1
    assign tw_nxt = '0;
  end

  always_comb begin
    sum_r  = '0;
    diff_r = '0;
    buf_in = stage_in;
    cand   = head;
    if (mode) begin
      sum_r  = add_q(head, stage_in);
      diff_r = mul_q(sub_q(head, stage_in), tw_factor);
    end else begin
      sum_r  = add_q(head, t_ct);
      diff_r = sub_q(head, t_ct);
    end
    if (phase && !byp) begin
      cand   = sum_r;
      buf_in = diff_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
      stage_out <= '0;
      tw_addr   <= '0;
      fifo      <= '0;
    end else if (clear) begin
      cnt       <= '0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
      tw_addr   <= '0;
    end else if (accept) begin
      cnt     <= cnt_nxt;
      tw_addr <= tw_nxt;
      fifo[0] <= buf_in;
      for (int i = 1; i < D; i++) fifo[i] <= fifo[i-1];
      out_valid <= primed;
      if (primed) stage_out <= cand;
      if (cnt_nxt == CNT_D) primed <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Self-checking bench for sdf_stage_ctrl: vector table, hand corner cases and a randomized run against a frame-level model.
module tb_sdf_stage_ctrl;
  localparam int DW = 64;
  localparam longint unsigned Q = 7681;
  localparam int D = 4;

  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, mode = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] stage_in = '0, tw_factor = '0;
  logic [1:0] tw_addr;
  logic out_valid;
  logic [DW-1:0] stage_out;
  logic clear1 = 1'b0, mode1 = 1'b0, in_valid1 = 1'b0;
  logic [DW-1:0] stage_in1 = '0, tw_factor1 = '0;
  logic [0:0] tw_addr1;
  logic out_valid1;
  logic [DW-1:0] stage_out1;
`ifdef SDF_BYPASS_EN
  logic bypass = 1'b0, bypass1 = 1'b0;
`endif

  sdf_stage_ctrl #(.DATA_W(DW), .MODULUS(7681), .DEPTH_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
`ifdef SDF_BYPASS_EN
    .bypass(bypass),
`endif
    .in_valid(in_valid), .stage_in(stage_in), .tw_factor(tw_factor),
    .tw_addr(tw_addr), .out_valid(out_valid), .stage_out(stage_out));

  sdf_stage_ctrl #(.DATA_W(DW), .MODULUS(7681), .DEPTH_LOG2(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .mode(mode1),
`ifdef SDF_BYPASS_EN
    .bypass(bypass1),
`endif
    .in_valid(in_valid1), .stage_in(stage_in1), .tw_factor(tw_factor1),
    .tw_addr(tw_addr1), .out_valid(out_valid1), .stage_out(stage_out1));

  always #5 clk = ~clk;

  int checks = 0, passed = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Frame-level model: first half of each 2D-sample frame is stored, second half pairs with it.
  int m_n;
  bit m_primed, m_byp, e_v;
  longint unsigned xb[D], pd[D], e_out;
  int e_addr;
  longint unsigned hist[$];

  task automatic m_reset();
    m_n = 0; m_primed = 0; e_v = 0; e_out = 0; e_addr = 0;
    for (int i = 0; i < D; i++) begin xb[i] = 0; pd[i] = 0; end
    hist = {};
    for (int i = 0; i < D; i++) hist.push_back(0);
  endtask

  task automatic m_step(input bit v, input bit c, input bit md, input longint unsigned x, input longint unsigned w);
    int j;
    longint unsigned cand, a, t, sum, diff;
    if (c) begin
      m_n = 0; m_primed = 0; e_v = 0; e_addr = 0;
    end else if (v) begin
      j = m_n % D;
      if (m_byp) cand = hist[hist.size() - D];
      else if (m_n < D) begin
        cand = pd[j]; xb[j] = x;
      end else begin
        a = xb[j];
        if (!md) begin
          t = (x * w) % Q; sum = (a + t) % Q; diff = (a + Q - t) % Q;
        end else begin
          sum = (a + x) % Q; diff = (((a + Q - x) % Q) * w) % Q;
        end
        cand = sum; pd[j] = diff;
      end
      hist.push_back(x);
      e_v = m_primed;
      if (m_primed) e_out = cand;
      m_n = (m_n + 1) % (2 * D);
      if (m_n == D) m_primed = 1;
      e_addr = m_byp ? 0 : m_n % D;
    end else e_v = 0;
  endtask

  task automatic cyc(input bit v, input bit c, input bit md, input longint unsigned x, input longint unsigned w);
    in_valid = v; clear = c; mode = md; stage_in = x; tw_factor = w;
`ifdef SDF_BYPASS_EN
    bypass = m_byp;
`endif
    m_step(v, c, md, x, w);
    @(posedge clk); #1;
    chk("out_valid", 64'(out_valid), 64'(e_v));
    if (e_v) chk("stage_out", stage_out, e_out);
    chk("tw_addr", 64'(tw_addr), 64'(e_addr));
  endtask

  task automatic cyc1(input bit v, input longint unsigned x, input bit ev, input longint unsigned eo);
    in_valid1 = v; stage_in1 = x; tw_factor1 = 1;
    @(posedge clk); #1;
    chk("d1_valid", 64'(out_valid1), 64'(ev));
    if (ev) chk("d1_out", stage_out1, eo);
    chk("d1_addr", 64'(tw_addr1), 64'd0);
  endtask

  typedef struct {
    bit v; bit md; longint unsigned x; longint unsigned w;
    bit ev; longint unsigned eo; int ea;
  } vec_t;
  vec_t tbl[32];

  initial begin
    bit rmode;
    bit rc;
    // reset state
    m_reset(); m_byp = 0;
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_out", stage_out, 64'd0);
    chk("rst_addr", 64'(tw_addr), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // cases 1 and 2 as a vector table
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) begin
        vec_t r;
        r.v = 1; r.md = k[0]; r.w = k ? 2 : 1;
        r.x = (i < 8) ? longint'(i + 1) : 0;
        r.ev = (i >= 4); r.ea = (i + 1) % 4;
        r.eo = (i < 4) ? 0 : (i < 8) ? longint'(2 * i - 2) : (i < 12) ? (k ? 7673 : 7677) : 0;
        tbl[k * 16 + i] = r;
      end
    for (int i = 0; i < 32; i++) begin
      if (i == 16) cyc(0, 1, 0, 0, 0);
      cyc(tbl[i].v, 0, tbl[i].md, tbl[i].x, tbl[i].w);
      chk("tbl_valid", 64'(out_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) chk("tbl_out", stage_out, tbl[i].eo);
      chk("tbl_addr", 64'(tw_addr), 64'(tbl[i].ea));
    end

    // case 3: toggling in_valid
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 0, (i < 8) ? longint'(i + 1) : 0, 1);
      cyc(0, 0, 0, 99, 1);
    end

    // case 4: clear after sample 6, restart
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, longint'(i + 1), 1);
    cyc(1, 1, 0, 55, 1);
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, (i < 8) ? longint'(i + 1) : 0, 1);

    // case 5: modular boundary
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 7680, 7680);
    cyc(1, 0, 0, 7680, 7680);
    chk("bnd_diff", stage_out, 64'd7679);
    // D = 1: samples 3, 4 then a phase-0 sample
    cyc1(1, 3, 0, 0);
    cyc1(1, 4, 1, 7);
    cyc1(1, 0, 1, 7680);
    cyc1(0, 0, 0, 0);

    // randomized run; mode only changes across a clear
    cyc(0, 1, 0, 0, 0);
    rmode = 0;
    for (int i = 0; i < 400; i++) begin
      rc = ($urandom_range(49) == 0);
      if (rc) rmode = $urandom_range(1);
      cyc(($urandom_range(3) != 0), rc, rmode, $urandom_range(7680), $urandom_range(7680));
    end

    // case 6: asynchronous reset mid-frame, then case 1 again
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, longint'(i + 1), 1);
    in_valid = 0; rst_n = 1'b0;
    #2;
    chk("amid_valid", 64'(out_valid), 64'd0);
    chk("amid_out", stage_out, 64'd0);
    chk("amid_addr", 64'(tw_addr), 64'd0);
    m_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, (i < 8) ? longint'(i + 1) : 0, 1);

`ifdef SDF_BYPASS_EN
    rst_n = 1'b0; #2; m_reset(); m_byp = 1;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 24; i++) cyc(($urandom_range(3) != 0), 0, 0, $urandom_range(7680), 3);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
